// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader for the instruction memory.
// Accepts bytes over a valid/ready handshake and issues registered byte
// writes starting at a programmable base address. Writes that would land
// outside the memory are consumed without a write and end the load in ERR.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN builds a modulo-256 running
// sum of written bytes; without it the checksum output is tied to zero.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | accepting bytes, byte_ready high
// DONE  | all requested bytes written
// ERR   | a byte addressed past the end of memory was consumed
module imem_loader #(
    parameter int MEM_BYTES = 201,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [63:0]      base_addr,
    input  logic [LEN_W-1:0] length,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [63:0]      wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             done,
    output logic             load_error,
    output logic [LEN_W-1:0] byte_count,
    output logic [7:0]       checksum
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]       state;
    logic [63:0]      base_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_inc;
    logic [63:0]      addr_cur;
    logic             in_range;
    logic             handshake;
    logic             start_ok;

    // Handshake, target address and range decode for the byte on the bus.
    always_comb begin
        handshake = byte_valid && (state == ST_LOAD);
        start_ok  = start && (state != ST_LOAD);
        addr_cur  = base_q + 64'(count_q);
        in_range  = addr_cur < 64'(MEM_BYTES);
        count_inc = count_q + LEN_W'(1);
    end

    // Status outputs are pure decodes of the state register.
    always_comb begin
        byte_ready = (state == ST_LOAD);
        busy       = (state == ST_LOAD);
        done       = (state == ST_DONE);
        load_error = (state == ST_ERR);
        byte_count = count_q;
    end

    // State transitions, byte counting and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_ok) begin
                base_q  <= base_addr;
                len_q   <= length;
                count_q <= '0;
                state   <= (length == '0) ? ST_DONE : ST_LOAD;
            end else if (handshake) begin
                // Out-of-range bytes still count so the source sees progress.
                count_q <= count_inc;
                if (in_range) begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr_cur;
                    wr_data <= byte_in;
                    if (count_inc == len_q) begin
                        state <= ST_DONE;
                    end
                end else begin
                    state <= ST_ERR;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    // Running sum of in-range bytes, updated on the same edge as wr_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (handshake && in_range) begin
            sum_q <= sum_q + byte_in;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
